quadrature_sampler: RTL and testbench

Periodic sampling controller for the quadrature encoder counter. Every PERIOD clocks it snapshots the encoder's 32-bit position and direction, and computes a saturated signed velocity delta against the last consumer-accepted sample. It presents the result on a valid/ready output and sequences zeroing of the encoder through the encoder's synchronous active-high reset input. It sits between the encoder and the motor-control/telemetry consumer.

---
 rtl/quadrature_sampler.sv | 150 +++++++++++++++
 tb/tb_quadrature_sampler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/quadrature_sampler.sv
// Periodic position/velocity sampler for a quadrature encoder counter.
// Emits a saturated signed delta on a valid/ready port and sequences encoder zeroing.
module quadrature_sampler #(
   parameter int PERIOD = 1000,
   parameter int DW     = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          zero_req,
   input  logic [31:0]   count,
   input  logic          dir,
   output logic          enc_reset,
   output logic          s_valid,
   input  logic          s_ready,
   output logic [31:0]   s_pos,
   output logic [DW-1:0] s_delta,
   output logic          s_dir,
   output logic          s_sat,
   output logic [7:0]    overrun_cnt
);

   localparam int TW = $clog2(PERIOD);
   localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);
   localparam logic signed [31:0] DMAX = 32'sh7FFF_FFFF >>> (32 - DW);
   localparam logic signed [31:0] DMIN = ~DMAX;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      ZERO  = 2'd2
   } state_t;

   state_t         state_r;
   logic [TW-1:0]  timer_r;
   logic [31:0]    ref_r;
   logic           zero_pend_r;

   logic           accept_s;
   logic           tick_s;
   logic           zero_go_s;
   logic [31:0]    ref_eff_s;
   logic [DW:0]    sat_res_s;

   // Modular 32-bit difference read as signed, clamped to DW bits; MSB flags clamping.
   function automatic logic [DW:0] sat_delta(input logic [31:0] diff);
      logic signed [31:0] d;
      logic [DW:0]        r;
      d = signed'(diff);
      if (d > DMAX) begin
         r = {1'b1, DMAX[DW-1:0]};
      end else if (d < DMIN) begin
         r = {1'b1, DMIN[DW-1:0]};
      end else begin
         r = {1'b0, diff[DW-1:0]};
      end
      return r;
   endfunction

   // Handshake, tick and zero decode plus the delta against the effective reference.
   always_comb begin
      accept_s  = s_valid & s_ready;
      tick_s    = (state_r == COUNT) && (timer_r == LAST);
      zero_go_s = zero_pend_r && (state_r != ZERO);
      ref_eff_s = accept_s ? s_pos : ref_r;
      sat_res_s = sat_delta(count - ref_eff_s);
   end

   // Sequencer, capture registers and overrun accounting.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         timer_r     <= '0;
         ref_r       <= 32'd0;
         zero_pend_r <= 1'b0;
         enc_reset   <= 1'b0;
         s_valid     <= 1'b0;
         s_pos       <= 32'd0;
         s_delta     <= '0;
         s_dir       <= 1'b0;
         s_sat       <= 1'b0;
         overrun_cnt <= 8'd0;
      end else begin
         enc_reset <= 1'b0;
         if (zero_go_s) begin
            // Zero beats a coincident tick; a held sample is dropped without counting.
            state_r     <= ZERO;
            timer_r     <= '0;
            enc_reset   <= 1'b1;
            ref_r       <= 32'd0;
            s_valid     <= 1'b0;
            zero_pend_r <= zero_req;
         end else begin
            if (zero_req) begin
               zero_pend_r <= 1'b1;
            end else begin
               zero_pend_r <= zero_pend_r;
            end
            case (state_r)
               IDLE: begin
                  timer_r <= '0;
                  state_r <= enable ? COUNT : IDLE;
               end
               COUNT: begin
                  if (!enable) begin
                     state_r <= IDLE;
                     timer_r <= '0;
                  end else if (timer_r == LAST) begin
                     timer_r <= '0;
                  end else begin
                     timer_r <= timer_r + TW'(1);
                  end
               end
               ZERO: begin
                  timer_r <= '0;
                  state_r <= enable ? COUNT : IDLE;
               end
               default: begin
                  timer_r <= '0;
                  state_r <= IDLE;
               end
            endcase
            if (tick_s) begin
               s_pos   <= count;
               s_dir   <= dir;
               s_delta <= sat_res_s[DW-1:0];
               s_sat   <= sat_res_s[DW];
               s_valid <= 1'b1;
               if (accept_s) begin
                  ref_r <= s_pos;
               end else begin
                  ref_r <= ref_r;
               end
               if (s_valid && !s_ready && (overrun_cnt != 8'd255)) begin
                  overrun_cnt <= overrun_cnt + 8'd1;
               end else begin
                  overrun_cnt <= overrun_cnt;
               end
            end else if (accept_s) begin
               ref_r   <= s_pos;
               s_valid <= 1'b0;
            end else begin
               ref_r   <= ref_r;
               s_valid <= s_valid;
            end
         end
      end
   end

endmodule

// File: tb/tb_quadrature_sampler.sv
// Directed bench for quadrature_sampler with PERIOD=8, DW=16.
module tb_quadrature_sampler;

   localparam int PERIOD = 8;
   localparam int DW     = 16;
   localparam logic [31:0] B = 32'h8000_0003;

   logic          clk;
   logic          reset;
   logic          enable;
   logic          zero_req;
   logic [31:0]   count;
   logic          dir;
   logic          enc_reset;
   logic          s_valid;
   logic          s_ready;
   logic [31:0]   s_pos;
   logic [DW-1:0] s_delta;
   logic          s_dir;
   logic          s_sat;
   logic [7:0]    overrun_cnt;

   int tests_r;
   int fails_r;
   int ec;

   quadrature_sampler #(.PERIOD(PERIOD), .DW(DW)) dut (
      .clk(clk), .reset(reset), .enable(enable), .zero_req(zero_req),
      .count(count), .dir(dir), .enc_reset(enc_reset), .s_valid(s_valid),
      .s_ready(s_ready), .s_pos(s_pos), .s_delta(s_delta), .s_dir(s_dir),
      .s_sat(s_sat), .overrun_cnt(overrun_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_r++;
      if (got !== exp) begin
         fails_r++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, got, exp, ec);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      ec++;
   endtask

   task automatic run_until(input int target);
      while (ec < target) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tests_r = 0; fails_r = 0; ec = 0;
      reset = 1'b0; enable = 1'b0; zero_req = 1'b0; count = 32'd0; dir = 1'b0; s_ready = 1'b0;
      step(); step();
      check_eq("rst_valid", {31'd0, s_valid}, 32'd0);
      check_eq("rst_pos", s_pos, 32'd0);
      check_eq("rst_delta", {16'd0, s_delta}, 32'd0);
      check_eq("rst_ovr", {24'd0, overrun_cnt}, 32'd0);
      check_eq("rst_encrst", {31'd0, enc_reset}, 32'd0);
      check_eq("rst_sat_dir", {30'd0, s_sat, s_dir}, 32'd0);

      // Basic ramp: count advances every 4 clocks, ticks at edges 9,17,25.
      reset = 1'b1; enable = 1'b1; s_ready = 1'b1; dir = 1'b1; ec = 0;
      for (int i = 1; i <= 25; i++) begin
         step();
         check_eq("basic_valid", {31'd0, s_valid}, {31'd0, (i == 9 || i == 17 || i == 25)});
         if (i == 9 || i == 17 || i == 25) begin
            check_eq("basic_delta", {16'd0, s_delta}, 32'd2);
            check_eq("basic_sat", {31'd0, s_sat}, 32'd0);
            check_eq("basic_dir", {31'd0, s_dir}, 32'd1);
         end
         count = 32'(i / 4);
      end
      check_eq("basic_ovr", {24'd0, overrun_cnt}, 32'd0);

      // Saturation positive, negative, then wrap across 0x7FFFFFFF.
      run_until(26); count = 32'd40006;
      run_until(33);
      check_eq("satp_delta", {16'd0, s_delta}, 32'h7FFF);
      check_eq("satp_sat", {31'd0, s_sat}, 32'd1);
      check_eq("satp_pos", s_pos, 32'd40006);
      run_until(34); count = 32'd6;
      run_until(41);
      check_eq("satn_delta", {16'd0, s_delta}, 32'h8000);
      check_eq("satn_sat", {31'd0, s_sat}, 32'd1);
      run_until(42); count = 32'h7FFF_FFFF;
      run_until(50); count = B;
      run_until(57);
      check_eq("wrap_delta", {16'd0, s_delta}, 32'd4);
      check_eq("wrap_sat", {31'd0, s_sat}, 32'd0);

      // Backpressure over three ticks.
      run_until(58); s_ready = 1'b0; count = B + 32'd10;
      run_until(65); count = B + 32'd20;
      run_until(70);
      check_eq("bp_hold_pos", s_pos, B + 32'd10);
      check_eq("bp_hold_delta", {16'd0, s_delta}, 32'd10);
      run_until(73); count = B + 32'd30;
      run_until(81);
      check_eq("bp_pos", s_pos, B + 32'd30);
      check_eq("bp_delta", {16'd0, s_delta}, 32'd30);
      check_eq("bp_ovr", {24'd0, overrun_cnt}, 32'd2);
      s_ready = 1'b1;
      run_until(82);
      check_eq("bp_accept_valid", {31'd0, s_valid}, 32'd0);
      count = B + 32'd35;
      run_until(89);
      check_eq("bp_next_delta", {16'd0, s_delta}, 32'd5);

      // Accept and capture on the same edge.
      s_ready = 1'b0; count = B + 32'd65;
      run_until(96);
      check_eq("same_held_valid", {31'd0, s_valid}, 32'd1);
      check_eq("same_held_pos", s_pos, B + 32'd35);
      s_ready = 1'b1;
      run_until(97);
      check_eq("same_valid", {31'd0, s_valid}, 32'd1);
      check_eq("same_delta", {16'd0, s_delta}, 32'd30);
      check_eq("same_pos", s_pos, B + 32'd65);
      check_eq("same_ovr", {24'd0, overrun_cnt}, 32'd2);

      // Zero pending when the tick arrives with a held sample.
      s_ready = 1'b0;
      run_until(103); zero_req = 1'b1;
      run_until(104); zero_req = 1'b0;
      run_until(105);
      check_eq("zero_valid", {31'd0, s_valid}, 32'd0);
      check_eq("zero_encrst", {31'd0, enc_reset}, 32'd1);
      check_eq("zero_pos_kept", s_pos, B + 32'd65);
      check_eq("zero_ovr", {24'd0, overrun_cnt}, 32'd2);
      run_until(106);
      check_eq("zero_encrst_end", {31'd0, enc_reset}, 32'd0);
      count = 32'd0;
      run_until(110); count = 32'd7;
      run_until(113);
      check_eq("zero_no_early", {31'd0, s_valid}, 32'd0);
      run_until(114);
      check_eq("zero_next_valid", {31'd0, s_valid}, 32'd1);
      check_eq("zero_next_delta", {16'd0, s_delta}, 32'd7);

      // Asynchronous reset mid-period with a held sample.
      run_until(119);
      #2 reset = 1'b0;
      #1;
      check_eq("arst_valid", {31'd0, s_valid}, 32'd0);
      check_eq("arst_pos", s_pos, 32'd0);
      check_eq("arst_delta", {16'd0, s_delta}, 32'd0);
      check_eq("arst_ovr", {24'd0, overrun_cnt}, 32'd0);
      #1 reset = 1'b1; s_ready = 1'b1;
      n = 0;
      while (!s_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("arst_latency", 32'(n), 32'(PERIOD + 1));
      check_eq("arst_delta_after", {16'd0, s_delta}, 32'd7);

      $display("[TB] %0d tests run, %0d failed", tests_r, fails_r);
      $finish;
   end

endmodule
